// File: rtl/la_mem_arbiter_if.sv
// Shared-memory bus bundle for la_mem_arbiter: both master request/response
// channels, the slave port and the grant vector.
interface la_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic              m0_ack;
    logic              m0_err;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [3:0]        m1_sel;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic              m1_err;
    logic [DATA_W-1:0] m1_rdata;

    logic              s_req;
    logic              s_we;
    logic [3:0]        s_sel;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [DATA_W-1:0] s_rdata;
    logic              s_ready;

    logic [1:0]        grant;

    // Arbiter side: drives the slave port, the master responses and grant.
    modport master (
        input  m0_req, m0_addr,
        input  m1_req, m1_we, m1_sel, m1_addr, m1_wdata,
        input  s_rdata, s_ready,
        output m0_ack, m0_err, m0_rdata,
        output m1_ack, m1_err, m1_rdata,
        output s_req, s_we, s_sel, s_addr, s_wdata,
        output grant
    );

    // Environment side: the two requesting masters and the memory slave.
    modport slave (
        output m0_req, m0_addr,
        output m1_req, m1_we, m1_sel, m1_addr, m1_wdata,
        output s_rdata, s_ready,
        input  m0_ack, m0_err, m0_rdata,
        input  m1_ack, m1_err, m1_rdata,
        input  s_req, s_we, s_sel, s_addr, s_wdata,
        input  grant
    );
endinterface

// File: rtl/la_mem_arbiter.sv
// Two-master arbiter/sequencer for the shared LA_spoc memory port: one
// transaction at a time, alternating priority on ties, slave-wait timeout.
module la_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    la_mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              last_m1_q, last_m1_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              s_req_q, s_req_d;
    logic              s_we_q, s_we_d;
    logic [3:0]        s_sel_q, s_sel_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic [1:0]        grant_q, grant_d;
    logic              m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
    logic              m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic              pick_m1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_m1_q  <= 1'b0;
            cnt_q      <= '0;
            s_req_q    <= 1'b0;
            s_we_q     <= 1'b0;
            s_sel_q    <= '0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            grant_q    <= '0;
            m0_ack_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_ack_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            last_m1_q  <= last_m1_d;
            cnt_q      <= cnt_d;
            s_req_q    <= s_req_d;
            s_we_q     <= s_we_d;
            s_sel_q    <= s_sel_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            grant_q    <= grant_d;
            m0_ack_q   <= m0_ack_d;
            m0_err_q   <= m0_err_d;
            m0_rdata_q <= m0_rdata_d;
            m1_ack_q   <= m1_ack_d;
            m1_err_q   <= m1_err_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Next-state logic computes the next value of every output register.
    always_comb begin
        state_d    = state_q;
        last_m1_d  = last_m1_q;
        cnt_d      = cnt_q;
        s_req_d    = s_req_q;
        s_we_d     = s_we_q;
        s_sel_d    = s_sel_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        grant_d    = grant_q;
        m0_ack_d   = 1'b0;
        m0_err_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_ack_d   = 1'b0;
        m1_err_d   = 1'b0;
        m1_rdata_d = m1_rdata_q;
        // On a tie the master not served last wins.
        pick_m1    = bus.m1_req & (~bus.m0_req | ~last_m1_q);

        case (state_q)
            IDLE: begin
                if (bus.m0_req | bus.m1_req) begin
                    s_req_d = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                    if (pick_m1) begin
                        grant_d   = 2'b10;
                        s_we_d    = bus.m1_we;
                        s_sel_d   = bus.m1_sel;
                        s_addr_d  = bus.m1_addr;
                        s_wdata_d = bus.m1_wdata;
                    end else begin
                        grant_d  = 2'b01;
                        s_we_d   = 1'b0;
                        s_sel_d  = 4'hF;
                        s_addr_d = bus.m0_addr;
                    end
                end
            end
            BUSY: begin
                if (bus.s_ready || cnt_q == CNT_LAST) begin
                    s_req_d   = 1'b0;
                    last_m1_d = grant_q[1];
                    state_d   = RESP;
                    if (grant_q[1]) begin
                        m1_ack_d   = 1'b1;
                        m1_err_d   = ~bus.s_ready;
                        m1_rdata_d = bus.s_ready ? bus.s_rdata : '0;
                    end else begin
                        m0_ack_d   = 1'b1;
                        m0_err_d   = ~bus.s_ready;
                        m0_rdata_d = bus.s_ready ? bus.s_rdata : '0;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.s_req    = s_req_q;
    assign bus.s_we     = s_we_q;
    assign bus.s_sel    = s_sel_q;
    assign bus.s_addr   = s_addr_q;
    assign bus.s_wdata  = s_wdata_q;
    assign bus.grant    = grant_q;
    assign bus.m0_ack   = m0_ack_q;
    assign bus.m0_err   = m0_err_q;
    assign bus.m0_rdata = m0_rdata_q;
    assign bus.m1_ack   = m1_ack_q;
    assign bus.m1_err   = m1_err_q;
    assign bus.m1_rdata = m1_rdata_q;
endmodule

// File: doc/la_mem_arbiter.md
# la_mem_arbiter

Two-master arbiter and sequencer for the single shared memory port of the LA_spoc SoC. It arbitrates between the instruction-fetch master (m0, read-only) and the load/store master (m1) and runs one transaction at a time on the slave port. The slave port has variable latency. The block issues a registered request, waits for slave ready or a timeout, then returns a one-cycle acknowledge with registered read data.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, slave-wait cycles before an error response; legal range 1..255
- clk  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- m0_req  in  1  fetch request; held high until m0_ack
- m0_addr  in  ADDR_W  fetch address
- m0_ack  out  1  one-cycle completion pulse
- m0_err  out  1  valid with m0_ack; 1 means timeout
- m0_rdata  out  DATA_W  read data; valid with m0_ack
- m1_req  in  1  load/store request; held until m1_ack
- m1_we  in  1  1 means write
- m1_sel  in  4  byte enables
- m1_addr  in  ADDR_W  address
- m1_wdata  in  DATA_W  write data
- m1_ack, m1_err, m1_rdata  out  1/1/DATA_W  same semantics as m0
- s_req  out  1  slave request; held until s_ready or timeout
- s_we  out  1  slave write enable
- s_sel  out  4  slave byte enables
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_rdata  in  DATA_W  slave read data; valid when s_ready
- s_ready  in  1  slave completion
- grant  out  2  one-hot owner of the slave port: bit0 = m0, bit1 = m1

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, any request: pick the winner, latch its command into the s_* registers, set s_req=1, set grant, clear the wait counter, go to BUSY.
- Arbitration:
  - Only one master requesting: that master wins.
  - Both requesting: the master not served last wins.
  - last_grant resets to m0, so the first tie goes to m1.
- m0 transactions always drive s_we=0 and s_sel=4'hF; s_wdata holds its previous value.
- BUSY with s_ready=1:
  - Capture s_rdata into the winner's rdata register.
  - Set s_req=0, pulse the winner's ack with err=0.
  - Update last_grant and go to RESP.
- BUSY with s_ready=0: increment the counter. When the counter reaches TIMEOUT-1 (i.e. on the TIMEOUT-th BUSY cycle without s_ready):
  - Set s_req=0.
  - Pulse ack with err=1 and rdata=0.
  - Update last_grant and go to RESP.
- s_ready on the same cycle the timeout would fire: s_ready wins, normal response.
- RESP: ack and err return to 0, grant clears to 00, go to IDLE.
- Master obligations:
  - Keep req and all command inputs stable from req assertion until ack is sampled.
  - Deassert req at the edge where ack is sampled high.
  - A req seen high in IDLE is always a new transaction.
- Requests from the losing master stay pending; nothing is dropped.
- A master deasserting req mid-transaction is illegal. The transaction completes regardless.
- Reset (rst=0, asynchronous):
  - State goes to IDLE; last_grant goes to m0.
  - All outputs go to 0: s_req, s_we, s_sel, s_addr, s_wdata, grant, both acks, both errs, both rdata.
  - Reset mid-BUSY abandons the transaction with no ack. s_req drops in the same cycle, without waiting for a clock edge.
- All outputs are registered; no combinational input-to-output paths.

## Timing
- Req seen in IDLE at cycle 0: s_req=1 from cycle 1.
- s_ready first sampled high in cycle k (k≥1): ack=1 in cycle k+1 and s_req=0 in cycle k+1.
- Minimum latency, req to ack: 2 cycles (slave ready in cycle 1).
- Sequence: RESP at cycle k+1, IDLE at cycle k+2.
- Best-case throughput: one transaction per 3 cycles.
- Timeout: if s_ready never rises, ack+err=1 in cycle TIMEOUT+1.
- s_ready is ignored outside BUSY.
- grant is high from cycle 1 through cycle k+1 (i.e. through the ack/RESP cycle), then clears to 00.

## Test plan
- Reset then single m0 read, addr 0x1C000000, slave ready in cycle 1 with s_rdata 0x02800C00:
  - Required: m0_ack=1 in cycle 2, m0_rdata=0x02800C00, err=0, s_we=0, s_sel=F.
- m1 write, addr 0x100, wdata 0xDEADBEEF, sel 0011, slave ready after 4 wait cycles:
  - Required: s_* lines match the command while s_req=1; m1_ack exactly once.
- m0 and m1 both request from reset:
  - Required: m1 served first, then m0, then m1 again on a repeated tie.
  - Neither master is starved across 8 back-to-back tie transactions.
- Slave never ready, TIMEOUT=15:
  - Required: m1_ack=1, m1_err=1, m1_rdata=0 in cycle 16; s_req low from cycle 16.
  - A following request completes normally.
- s_ready asserted exactly in the timeout cycle:
  - Required: err=0 and the slave data is returned.
- rst pulled low mid-BUSY (asynchronous, between clock edges):
  - Required: s_req, grant and ack are 0 immediately, with no ack ever issued.
  - After rst goes high, a fresh m0 request completes in 2 cycles.
